aes_cmd_sequencer: RTL
======================

Name: aes_cmd_sequencer

Overview:
Command-level controller for the memory-mapped AES peripheral. Accepts one AES command from the CPU custom-instruction path (load key, encrypt block, decrypt block). Executes it as a fixed sequence of single-beat bus transactions: key/block writes, CONFIG write, CTRL write, STATUS polling, RESULT reads. Returns the 128-bit result, or an error, through a valid/ready response port. Sits between the CPU execute stage and the AES register block on the peripheral bus.

Parameters:
AW, 8, bus word-address width
POLL_LIMIT, 1024, maximum STATUS reads before timeout error
CNT_W, 11, width of poll counter (must hold POLL_LIMIT)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  sequencer idle, accepts command
cmd_op_i  in  2  aes_op_e: OP_LOAD_KEY=0, OP_ENC=1, OP_DEC=2 (3 reserved)
cmd_keylen_i  in  1  0=128-bit key, 1=256-bit key
cmd_data_i  in  256  key (load key) or block in [127:0] (enc/dec)
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_data_o  out  128  result block (zero for load key or error)
rsp_err_o  out  1  timeout or reserved op
bus_req_o  out  1  transaction request
bus_we_o  out  1  1=write
bus_addr_o  out  AW  word address
bus_wdata_o  out  32  write data
bus_gnt_i  in  1  request accepted this cycle
bus_rvalid_i  in  1  read data valid
bus_rdata_i  in  32  read data

Behaviour:
- Reset (rst_ni=0 at posedge): state IDLE; cmd_ready_o=1; rsp_valid_o=0; rsp_err_o=0; rsp_data_o=0; bus_req_o=0; bus_we_o=0; bus_addr_o=0; bus_wdata_o=0; counters cleared. Reset mid-sequence aborts with no further bus activity. Any in-flight read is dropped; a bus_rvalid_i arriving after reset is ignored.
- Command accept: cmd_valid_i & cmd_ready_o. Latch op, keylen, data. cmd_ready_o=0 from the next cycle until the response handshake completes.
- Bus rules:
  - One outstanding transaction.
  - bus_req_o/we/addr/wdata held stable until bus_gnt_i. A write completes on the gnt cycle.
  - A read completes on bus_rvalid_i, which arrives no earlier than one cycle after gnt. bus_req_o=0 while waiting for rvalid.
- Word order: big-endian. Word i = data[W*32-1-32i -: 32], where W = number of words.
- States:
  - IDLE: accept command. Reserved op goes to RESP with err=1, without any bus traffic.
  - WR_KEY: write KEY0+i for i=0..3 (keylen=0) or 0..7 (keylen=1). Then WR_CFG.
  - WR_BLOCK: write BLOCK0+i, i=0..3, from data[127:0]. Then WR_CFG.
  - WR_CFG: write CONFIG = {30'b0, keylen, encdec}, with encdec=1 for ENC, 0 for DEC/LOAD_KEY.
  - WR_CTRL: write CTRL = 32'h1 (init) for LOAD_KEY, 32'h2 (next) for ENC/DEC.
  - POLL_REQ/POLL_WAIT: read STATUS. Done bit is bit0 (ready) for LOAD_KEY, bit1 (valid) for ENC/DEC.
    - Done set: LOAD_KEY goes to RESP; ENC/DEC goes to RD.
    - Done clear: poll count+1, back to POLL_REQ.
    - Count reaches POLL_LIMIT without done: RESP with err=1, data=0.
  - RD_REQ/RD_WAIT: read RESULT0+i, i=0..3. Word i lands in rsp_data_o[127-32i -: 32]. Then RESP.
  - RESP: rsp_valid_o=1, held with stable data/err until rsp_ready_i. Then IDLE with cmd_ready_o=1 the next cycle. rsp_ready_i outside RESP is ignored.
- Minimum latency with gnt same cycle and rvalid next cycle, accept to rsp_valid_o:
  - LOAD_KEY 128: 4 key + CFG + CTRL + 1 poll (2 cycles) = 8 cycles, +1 to RESP.
  - ENC: 4 + 1 + 1 + 2 + 4×2 = 16 cycles, +1 to RESP.
- rsp_data_o is cleared at command accept. A partial result is never visible.

Decomposition:
- Package aes_seq_pkg holds:
  - aes_op_e.
  - Word addresses: ADDR_CTRL=8'h08, ADDR_STATUS=8'h09, ADDR_CONFIG=8'h0A, ADDR_KEY0=8'h10, ADDR_BLOCK0=8'h20, ADDR_RESULT0=8'h30.
  - CTRL_INIT=32'h1, CTRL_NEXT=32'h2, STATUS_READY_BIT=0, STATUS_VALID_BIT=1.
  - FSM state enum.
- Sub-module aes_bus_master: single-beat req/gnt/rvalid handshake. Takes a start pulse, we/addr/wdata; returns done and rdata. The FSM sequences words through it.

Test Plan:
- LOAD_KEY keylen=0, data[127:0]=000102030405060708090a0b0c0d0e0f, gnt immediate, STATUS=1 on first read -> writes 0x10..0x13 = 00010203..0c0d0e0f, CONFIG=0, CTRL=1, one STATUS read; rsp_valid err=0 data=0.
- ENC, block 00112233445566778899aabbccddeeff, model returns 69c4e0d86a7b0430d8cdb78070b4c55a after 3 polls -> writes BLOCK0..3, CONFIG=1, CTRL=2, 3 STATUS reads; rsp_data_o=69c4e0d8..b4c55a.
- LOAD_KEY keylen=1 -> 8 key writes to 0x10..0x17, CONFIG=32'h2.
- STATUS never valid, POLL_LIMIT=4 -> exactly 4 STATUS reads; rsp err=1 data=0; no RESULT reads.
- Random gnt/rvalid stalls, rsp_ready_i held low 5 cycles -> bus signals stable while stalled; rsp fields stable; cmd_ready_o=0 until handshake.
- rst_ni=0 during RD_WAIT, then cmd_op_i=3 -> outputs at reset values; stale rvalid ignored; reserved op gives err=1 with zero bus requests.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// Shared types, register map and helpers for the AES command sequencer.
package aes_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_KEY = 2'd0,
    OP_ENC      = 2'd1,
    OP_DEC      = 2'd2,
    OP_RSVD     = 2'd3
  } aes_op_e;

  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_CONFIG  = 8'h0A;
  localparam logic [7:0] ADDR_KEY0    = 8'h10;
  localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
  localparam logic [7:0] ADDR_RESULT0 = 8'h30;

  localparam logic [31:0] CTRL_INIT = 32'h1;
  localparam logic [31:0] CTRL_NEXT = 32'h2;
  localparam int unsigned STATUS_READY_BIT = 0;
  localparam int unsigned STATUS_VALID_BIT = 1;

  // POLL and RD each cover both the request and the rvalid wait; that split lives in the bus master
  typedef enum logic [2:0] {
    S_IDLE, S_WR_KEY, S_WR_BLOCK, S_WR_CFG, S_WR_CTRL, S_POLL, S_RD, S_RESP
  } seq_state_e;

  // Big-endian word i of the low nwords*32 bits of d
  function automatic logic [31:0] word_of(input logic [255:0] d, input logic [3:0] nwords,
                                          input logic [2:0] i);
    logic [255:0] sh;
    sh = d >> (32 * (int'(nwords) - 1 - int'(i)));
    return sh[31:0];
  endfunction

endpackage

// File: rtl/aes_bus_master.sv
// Single-beat req/gnt/rvalid handshake; the request is raised the cycle start is seen.
module aes_bus_master #(
  parameter int unsigned AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          done,
  output logic [31:0]   rdata,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [31:0]   bus_wdata_o,
  input  logic          bus_gnt_i,
  input  logic          bus_rvalid_i,
  input  logic [31:0]   bus_rdata_i
);

  logic pend_req;
  logic wait_rd;

  // Caller holds we/addr/wdata stable until done, so they pass straight through
  assign bus_req_o   = start | pend_req;
  assign bus_we_o    = we;
  assign bus_addr_o  = addr;
  assign bus_wdata_o = wdata;
  assign done        = (bus_req_o & bus_gnt_i & we) | (wait_rd & bus_rvalid_i);
  assign rdata       = bus_rdata_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_req <= 1'b0;
      wait_rd  <= 1'b0;
    end else begin
      if (wait_rd && bus_rvalid_i) wait_rd <= 1'b0;
      if (bus_req_o && bus_gnt_i) begin
        pend_req <= 1'b0;
        wait_rd  <= ~we;
      end else if (start) begin
        pend_req <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_cmd_sequencer.sv
// Runs one AES command as a fixed sequence of single-beat bus transactions
// and returns the result through a valid/ready response port.
module aes_cmd_sequencer #(
  parameter int unsigned AW         = 8,
  parameter int unsigned POLL_LIMIT = 1024,
  parameter int unsigned CNT_W      = 11
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [1:0]    cmd_op_i,
  input  logic          cmd_keylen_i,
  input  logic [255:0]  cmd_data_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [127:0]  rsp_data_o,
  output logic          rsp_err_o,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [31:0]   bus_wdata_o,
  input  logic          bus_gnt_i,
  input  logic          bus_rvalid_i,
  input  logic [31:0]   bus_rdata_i
);
  import aes_seq_pkg::*;

  seq_state_e       state;
  aes_op_e          op;
  logic             keylen;
  logic [255:0]     data;
  logic [2:0]       idx;
  logic [CNT_W-1:0] poll_cnt;
  logic [95:0]      res;
  logic             start, we, done;
  logic [AW-1:0]    addr;
  logic [31:0]      wdata, rdata;
  logic [2:0]       last_key;
  logic [3:0]       key_words;
  logic             done_bit;

  assign last_key  = keylen ? 3'd7 : 3'd3;
  assign key_words = keylen ? 4'd8 : 4'd4;
  assign done_bit  = (op == OP_LOAD_KEY) ? rdata[STATUS_READY_BIT] : rdata[STATUS_VALID_BIT];

  aes_bus_master #(.AW(AW)) u_bus (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .start(start), .we(we), .addr(addr), .wdata(wdata),
    .done(done), .rdata(rdata),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i)
  );

  // Each bus-phase state has its transaction in flight; the next one is issued on done
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_data_o  <= '0;
      op          <= OP_LOAD_KEY;
      keylen      <= 1'b0;
      data        <= '0;
      idx         <= '0;
      poll_cnt    <= '0;
      res         <= '0;
      start       <= 1'b0;
      we          <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
    end else begin
      start <= 1'b0;
      unique case (state)
        S_IDLE: if (cmd_valid_i && cmd_ready_o) begin
          op          <= aes_op_e'(cmd_op_i);
          keylen      <= cmd_keylen_i;
          data        <= cmd_data_i;
          idx         <= '0;
          poll_cnt    <= '0;
          res         <= '0;
          cmd_ready_o <= 1'b0;
          rsp_data_o  <= '0;
          rsp_err_o   <= 1'b0;
          unique case (aes_op_e'(cmd_op_i))
            OP_LOAD_KEY: begin
              state <= S_WR_KEY;
              start <= 1'b1;
              we    <= 1'b1;
              addr  <= AW'(ADDR_KEY0);
              wdata <= word_of(cmd_data_i, cmd_keylen_i ? 4'd8 : 4'd4, 3'd0);
            end
            OP_ENC, OP_DEC: begin
              state <= S_WR_BLOCK;
              start <= 1'b1;
              we    <= 1'b1;
              addr  <= AW'(ADDR_BLOCK0);
              wdata <= cmd_data_i[127:96];
            end
            default: begin
              state       <= S_RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
            end
          endcase
        end
        S_WR_KEY, S_WR_BLOCK: if (done) begin
          start <= 1'b1;
          if (idx == ((state == S_WR_KEY) ? last_key : 3'd3)) begin
            state <= S_WR_CFG;
            addr  <= AW'(ADDR_CONFIG);
            wdata <= {30'b0, keylen, op == OP_ENC};
          end else begin
            idx <= idx + 3'd1;
            if (state == S_WR_KEY) begin
              addr  <= AW'(ADDR_KEY0) + AW'(idx + 3'd1);
              wdata <= word_of(data, key_words, idx + 3'd1);
            end else begin
              addr  <= AW'(ADDR_BLOCK0) + AW'(idx + 3'd1);
              wdata <= word_of(data, 4'd4, idx + 3'd1);
            end
          end
        end
        S_WR_CFG: if (done) begin
          state <= S_WR_CTRL;
          start <= 1'b1;
          addr  <= AW'(ADDR_CTRL);
          wdata <= (op == OP_LOAD_KEY) ? CTRL_INIT : CTRL_NEXT;
        end
        S_WR_CTRL: if (done) begin
          state <= S_POLL;
          start <= 1'b1;
          we    <= 1'b0;
          addr  <= AW'(ADDR_STATUS);
        end
        S_POLL: if (done) begin
          if (done_bit) begin
            if (op == OP_LOAD_KEY) begin
              state       <= S_RESP;
              rsp_valid_o <= 1'b1;
            end else begin
              state <= S_RD;
              start <= 1'b1;
              idx   <= '0;
              addr  <= AW'(ADDR_RESULT0);
            end
          end else if (poll_cnt == CNT_W'(POLL_LIMIT - 1)) begin
            state       <= S_RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
            start    <= 1'b1;
          end
        end
        S_RD: if (done) begin
          if (idx == 3'd3) begin
            state       <= S_RESP;
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= {res, rdata};
          end else begin
            res   <= {res[63:0], rdata};
            idx   <= idx + 3'd1;
            start <= 1'b1;
            addr  <= AW'(ADDR_RESULT0) + AW'(idx + 3'd1);
          end
        end
        S_RESP: if (rsp_ready_i) begin
          state       <= S_IDLE;
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
